// File: rtl/store_merge_unit.sv
// Store unit: narrows a register value to byte/half/word and writes it to word memory,
// using read-modify-write for sub-word sizes. Holds busy while a store is in flight.
module store_merge_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  // state | meaning
  // IDLE  | waiting for start; outputs quiet, mem_addr = 0
  // READ  | mem_rd_en high for the containing word
  // WAIT  | mem_rdata valid; merged word captured into mem_wdata
  // WRITE | mem_wr_en high for one cycle
  // DONE  | done pulse, err valid
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_lo;
  logic [DATA_W-1:0] merged;
  logic        misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = (addr[1:0] != 2'b00);
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // Little-endian lane merge over the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b10) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_lo[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_lo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      size_q    <= '0;
      lane_q    <= '0;
      wdata_lo  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            size_q   <= size;
            lane_q   <= addr[1:0];
            wdata_lo <= wdata[15:0];
            busy     <= 1'b1;
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              mem_addr <= {addr[ADDR_W-1:2], 2'b00};
              if (size == 2'b00) begin
                state     <= WRITE;
                mem_wr_en <= 1'b1;
                mem_wdata <= wdata;
              end else begin
                state     <= READ;
                mem_rd_en <= 1'b1;
              end
            end
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          mem_wdata <= merged;
          mem_wr_en <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          mem_wr_en <= 1'b0;
          done      <= 1'b1;
          err       <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          mem_addr <= '0;
          state    <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          mem_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: table of stores against a small synchronous RAM
// model, plus sequences for start-while-busy and reset during the read wait.
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        busy, done, err;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;

  store_merge_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .addr(addr), .wdata(wdata), .size(size),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM model with a preload port driven by the stimulus.
  logic [31:0] mem [16];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  int          wr_count = 0;
  int          rd_count = 0;

  always @(posedge Clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr[5:2]];
      rd_count  <= rd_count + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] init;
    logic [31:0] expw;
    logic        experr;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge Clk);
    pre_en  = 1'b0;
  endtask

  task automatic run_store(input vec_t v, input string tag);
    int n, done_cyc, wr0, rd0, bad_busy, bad_err;
    logic        got_err;
    logic [31:0] wr_addr;
    preload(v.addr[5:2], v.init);
    wr0 = wr_count; rd0 = rd_count;
    done_cyc = 0; bad_busy = 0; bad_err = 0; got_err = 1'b0; wr_addr = 32'hFFFF_FFFF;
    addr = v.addr; wdata = v.wdata; size = v.size; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    n = 1;
    while (n <= 10 && done_cyc == 0) begin
      if (!busy) bad_busy++;
      if (mem_wr_en) wr_addr = mem_addr;
      if (done) begin
        done_cyc = n;
        got_err  = err;
      end else if (err) begin
        bad_err++;
      end
      @(negedge Clk);
      n++;
    end
    check({tag, " latency"}, done_cyc, v.lat);
    check({tag, " err"}, {31'd0, got_err}, {31'd0, v.experr});
    check({tag, " busy while active"}, bad_busy, 0);
    check({tag, " err without done"}, bad_err, 0);
    check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
    check({tag, " write count"}, wr_count - wr0, v.experr ? 0 : 1);
    check({tag, " read count"}, rd_count - rd0, (v.experr || v.size == 2'b00) ? 0 : 1);
    if (!v.experr)
      check({tag, " write addr"}, wr_addr, {v.addr[31:2], 2'b00});
    check({tag, " memory word"}, mem[v.addr[5:2]], v.expw);
  endtask

  initial begin
    int n, wr1, wr2, ndone, acc, w0;
    vec_t rv;

    vecs[0] = '{32'h10, 32'hDEADBEEF, 2'b00, 32'h0000_0000, 32'hDEADBEEF, 1'b0, 2};
    vecs[1] = '{32'h22, 32'hFFFFFFAB, 2'b10, 32'h1122_3344, 32'h11AB_3344, 1'b0, 4};
    vecs[2] = '{32'h22, 32'h0000CAFE, 2'b01, 32'h1122_3344, 32'hCAFE_3344, 1'b0, 4};
    vecs[3] = '{32'h20, 32'h0000CAFE, 2'b01, 32'h1122_3344, 32'h1122_CAFE, 1'b0, 4};
    vecs[4] = '{32'h21, 32'h0000CAFE, 2'b01, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
    vecs[5] = '{32'h22, 32'hDEADBEEF, 2'b00, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
    vecs[6] = '{32'h20, 32'hDEADBEEF, 2'b11, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
    vecs[7] = '{32'h23, 32'h0000005A, 2'b10, 32'h1122_3344, 32'h5A22_3344, 1'b0, 4};
    vecs[8] = '{32'h0C, 32'h12345677, 2'b10, 32'hAABB_CCDD, 32'hAABB_CC77, 1'b0, 4};

    Reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (3) @(negedge Clk);
    check("reset outputs", {26'd0, busy, done, err, mem_rd_en, mem_wr_en, 1'b0}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 9; i++) begin
      run_store(vecs[i], $sformatf("vec%0d", i));
      @(negedge Clk);
    end

    // start held high while busy: second request must wait for busy=0.
    preload(4'd9, 32'hA0B0_C0D0);
    preload(4'd10, 32'h0000_0000);
    w0 = wr_count;
    addr = 32'h26; wdata = 32'h0000003C; size = 2'b10; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    addr = 32'h28; wdata = 32'h12345678; size = 2'b00;
    n = 1; wr1 = 0; wr2 = 0; ndone = 0; acc = 0;
    while (n <= 15 && ndone < 2) begin
      if (mem_wr_en) begin
        if (wr1 == 0) wr1 = n; else wr2 = n;
      end
      if (done) ndone++;
      if (!busy && acc == 0) acc = n;
      if (acc != 0 && n == acc + 1) start = 1'b0;
      @(negedge Clk);
      n++;
    end
    start = 1'b0;
    repeat (2) @(negedge Clk);
    check("busy seq first write cycle", wr1, 3);
    check("busy seq idle cycle", acc, 5);
    check("busy seq second write cycle", wr2, 6);
    check("busy seq done pulses", ndone, 2);
    check("busy seq write count", wr_count - w0, 2);
    check("busy seq byte word", mem[9], 32'hA03C_C0D0);
    check("busy seq word", mem[10], 32'h1234_5678);
    check("busy seq idle after", {31'd0, busy}, 32'd0);

    // Reset during WAIT abandons the write.
    preload(4'd12, 32'h0102_0304);
    w0 = wr_count;
    addr = 32'h31; wdata = 32'h000000EE; size = 2'b10; start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("reset-in-wait wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("reset-in-wait busy", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    check("reset-in-wait done", {31'd0, done}, 32'd0);
    check("reset-in-wait mem_addr", mem_addr, 32'd0);
    repeat (4) @(negedge Clk);
    check("reset-in-wait no write", wr_count - w0, 0);
    check("reset-in-wait memory", mem[12], 32'h0102_0304);
    rv = '{32'h31, 32'h000000EE, 2'b10, 32'h0102_0304, 32'h0102_EE04, 1'b0, 4};
    run_store(rv, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Memory-stage store unit that narrows a 32-bit register value into a byte or halfword and writes it into word-organised data memory. Sub-word stores use a read-modify-write sequence: read the containing word, merge the selected lanes, write the word back. Word stores bypass the read. It is the store-side counterpart of load-path sign extension. It sits between the MEM pipeline stage and the data memory port, and holds the pipeline stalled while a store is in flight.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width (fixed at 32; lane logic assumes 4 bytes)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- addr  in  ADDR_W  byte address of the store
- wdata  in  32  register value; low byte or low halfword is stored for sub-word sizes
- size  in  2  00 = word (sw), 01 = half (sh), 10 = byte (sb), 11 = reserved, treated as misaligned
- busy  out  1  high in every state except IDLE; drives the pipeline stall
- done  out  1  one-cycle pulse when the store completes or is rejected
- err  out  1  valid with done; 1 = misaligned or reserved request, no memory write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- mem_rd_en  out  1  read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_rd_en (synchronous RAM)
- mem_wr_en  out  1  write strobe, one cycle per store
- mem_wdata  out  32  merged word

## Operation
- One clock domain and one synchronous, active-high reset. All outputs are Moore outputs, decoded from state and registers only.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE with start=1: latch addr, wdata and size.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or size=11) → DONE with err=1.
  - size=00 → WRITE, with mem_wdata = wdata.
  - Otherwise → READ.
- READ: mem_rd_en=1 → WAIT.
- WAIT: capture mem_rdata into the merge register → WRITE.
- WRITE: mem_wr_en=1 for exactly one cycle → DONE.
- DONE: done=1 → IDLE.
- Lane mapping is little-endian. Byte lane k = bits [8k+7:8k], with k = addr[1:0].
  - Byte store: lane k ← wdata[7:0].
  - Half store: lanes {addr[1],1} and {addr[1],0} ← wdata[15:0].
  - All other lanes keep the value read from memory.
- mem_addr holds the latched word address from READ through WRITE. It is 0 in IDLE.
- start while busy=1 is ignored. No queuing.
- Reset values: state=IDLE; busy, done, err, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0; all latched registers = 0.
- Reset mid-operation: return to IDLE on the next edge and abandon any pending write. mem_wr_en must be 0 in the cycle after Reset is sampled high.

## Timing
- Accepting edge is E0.
- Word store:
  - E0+1: mem_wr_en=1.
  - E0+2: done=1.
  - Latency 2 cycles; busy is high for 2 cycles.
- Byte/half store:
  - E0+1: mem_rd_en=1.
  - E0+2: mem_rdata sampled.
  - E0+3: mem_wr_en=1.
  - E0+4: done=1.
  - Latency 4 cycles.
- Misaligned request: E0+1 has done=1 and err=1, with no mem_rd_en or mem_wr_en in any cycle.
- busy falls in the cycle after done. A new start is accepted at the first edge with busy=0. Issue rate is therefore one store per 3 cycles (word) or 5 cycles (sub-word).
- err is 0 whenever done is 0.

## Test plan
- Word store: addr=0x10, wdata=0xDEADBEEF, size=00 → no read; E0+1 has mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; E0+2 has done=1, err=0.
- Byte store: memory word at 0x20 = 0x11223344, addr=0x22, wdata=0xFFFFFFAB, size=10 → E0+3 has mem_wdata=0x11AB3344; done at E0+4.
- Half store: memory word at 0x20 = 0x11223344, addr=0x22, wdata=0x0000CAFE, size=01 → mem_wdata=0xCAFE3344. Repeat with addr=0x20 → mem_wdata=0x1122CAFE.
- Misaligned: addr=0x21, size=01 → E0+1 has done=1, err=1; mem_rd_en and mem_wr_en stay 0 throughout. Repeat with addr=0x22, size=00 and with size=11 → same response.
- start pulses during busy are ignored: exactly one write per accepted request, and the second request is accepted only after busy=0.
- Reset asserted in WAIT → next cycle state is IDLE, busy=0, no mem_wr_en ever issued; memory is unchanged; the following store completes normally.
